// File: rtl/mul_sched_pkg.sv
// Shared types and sizing helpers for the shared-multiplier scheduler and its arbiter.
package mul_sched_pkg;

  // Tag ids are stored at the widest supported size (NREQ <= 16) so the struct stays unparameterised.
  localparam int unsigned TAG_ID_W = 4;
  // Guard counter must hold MUL_LATENCY+1 for MUL_LATENCY up to 16.
  localparam int unsigned GUARD_W  = 5;

  function automatic int unsigned id_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter: search starts at i_ptr, pointer advances past the winner.
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = id_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_next_ptr
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant    = '0;
    o_next_ptr = i_ptr;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PW'((32'(i_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_next_ptr     = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one fixed-latency multiply unit among NREQ requesters; tags each issue and
// routes returned results back to the issuing requester, flagging tag/result mismatches.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned BWIDTH      = 1,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ*DATAWIDTH-1:0]          req_a_data,
  input  logic [NREQ*BWIDTH-1:0]             req_b_data,
  output logic [NREQ-1:0]                    rsp_valid,
  output logic [DATAWIDTH-1:0]               rsp_data,
  output logic                               m_axis_a_tvalid,
  output logic [DATAWIDTH-1:0]               m_axis_a_tdata,
  output logic                               m_axis_b_tvalid,
  output logic [BWIDTH-1:0]                  m_axis_b_tdata,
  input  logic                               s_axis_result_tvalid,
  input  logic [DATAWIDTH-1:0]               s_axis_result_tdata,
  output logic [$clog2(MUL_LATENCY+2)-1:0]   inflight,
  output logic                               err
);

  localparam int unsigned ID_W  = id_w(NREQ);
  localparam int unsigned INF_W = $clog2(MUL_LATENCY + 2);

  logic [ID_W-1:0]      r_ptr, w_next_ptr, w_gid;
  logic [NREQ-1:0]      w_grant;
  logic                 w_hs, w_en, w_match;
  logic [GUARD_W-1:0]   r_guard;
  logic [DATAWIDTH-1:0] w_a, r_a;
  logic [BWIDTH-1:0]    w_b, r_b;
  logic                 r_iss_vld;
  logic [ID_W-1:0]      r_iss_id;
  tag_t                 r_tag [MUL_LATENCY];
  tag_t                 w_head;
  logic [NREQ-1:0]      r_rsp_vld;
  logic [DATAWIDTH-1:0] r_rsp_data;
  logic [INF_W-1:0]     r_inflight;
  logic                 r_err;

  assign w_en = (r_guard == '0);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .i_en       (w_en),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  always_comb begin
    w_gid = '0;
    w_a   = '0;
    w_b   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gid = ID_W'(i);
        w_a   = req_a_data[i*DATAWIDTH +: DATAWIDTH];
        w_b   = req_b_data[i*BWIDTH +: BWIDTH];
      end
    end
  end

  assign w_hs    = |w_grant;
  assign w_head  = r_tag[MUL_LATENCY-1];
  assign w_match = w_head.vld & s_axis_result_tvalid;

  // Guard holds off grants until anything the unkept multiplier pipeline still carries has drained.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_guard <= GUARD_W'(MUL_LATENCY + 1);
    else if (r_guard != '0) r_guard <= r_guard - 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ptr     <= '0;
      r_iss_vld <= 1'b0;
      r_iss_id  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_ptr     <= w_next_ptr;
      r_iss_vld <= w_hs;
      r_iss_id  <= w_gid;
      r_a       <= w_a;
      r_b       <= w_b;
      r_tag[0]  <= '{vld: r_iss_vld, id: TAG_ID_W'(r_iss_id)};
      for (int unsigned i = 1; i < MUL_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      r_rsp_vld  <= w_match ? (NREQ'(1) << w_head.id) : '0;
      r_rsp_data <= w_match ? s_axis_result_tdata : '0;
      r_err      <= r_err | (w_en & (w_head.vld ^ s_axis_result_tvalid));
      unique case ({w_hs, w_head.vld})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready       = w_grant;
  assign m_axis_a_tvalid = r_iss_vld;
  assign m_axis_b_tvalid = r_iss_vld;
  assign m_axis_a_tdata  = r_a;
  assign m_axis_b_tdata  = r_b;
  assign rsp_valid       = r_rsp_vld;
  assign rsp_data        = r_rsp_data;
  assign inflight        = r_inflight;
  assign err             = r_err;

endmodule

// File: tb/tb_mul_share_sched.sv
// Bench for mul_share_sched: two instances (latency 1 and 8), each with a behavioural multiply unit.
module tb_mul_share_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [NR*DW-1:0] a, input logic [NR-1:0] b, input int i);
    logic [DW-1:0] av;
    av = a[i*DW +: DW];
    return b[i] ? av : 32'd1;
  endfunction

  logic          rstn0, rstn1;
  logic [NR-1:0] rv0, rr0, sv0, rb0, rv1, rr1, sv1, rb1;
  logic [NR*DW-1:0] ra0, ra1;
  logic [DW-1:0] sd0, ma_d0, sr_d0, sd1, ma_d1, sr_d1;
  logic          ma_v0, mb_v0, sr_v0, err0, ma_v1, mb_v1, sr_v1, err1;
  logic [0:0]    mb_d0, mb_d1;
  logic [1:0]    inf0;
  logic [3:0]    inf1;
  logic          drop0 = 1'b0, stray0 = 1'b0;

  mul_share_sched #(.DATAWIDTH(DW), .BWIDTH(1), .NREQ(NR), .MUL_LATENCY(1)) dut0 (
    .aclk(clk), .aresetn(rstn0), .req_valid(rv0), .req_ready(rr0),
    .req_a_data(ra0), .req_b_data(rb0), .rsp_valid(sv0), .rsp_data(sd0),
    .m_axis_a_tvalid(ma_v0), .m_axis_a_tdata(ma_d0), .m_axis_b_tvalid(mb_v0), .m_axis_b_tdata(mb_d0),
    .s_axis_result_tvalid(sr_v0), .s_axis_result_tdata(sr_d0), .inflight(inf0), .err(err0)
  );

  mul_share_sched #(.DATAWIDTH(DW), .BWIDTH(1), .NREQ(NR), .MUL_LATENCY(8)) dut1 (
    .aclk(clk), .aresetn(rstn1), .req_valid(rv1), .req_ready(rr1),
    .req_a_data(ra1), .req_b_data(rb1), .rsp_valid(sv1), .rsp_data(sd1),
    .m_axis_a_tvalid(ma_v1), .m_axis_a_tdata(ma_d1), .m_axis_b_tvalid(mb_v1), .m_axis_b_tdata(mb_d1),
    .s_axis_result_tvalid(sr_v1), .s_axis_result_tdata(sr_d1), .inflight(inf1), .err(err1)
  );

  // Multiply units: result = a when b=1 else 1, no reset, fixed latency.
  logic [DW:0] u0 = '0;
  logic [DW:0] u1 [8] = '{default: '0};
  always @(posedge clk) begin
    u0    <= {ma_v0, mb_d0[0] ? ma_d0 : 32'd1};
    u1[0] <= {ma_v1, mb_d1[0] ? ma_d1 : 32'd1};
    for (int i = 1; i < 8; i++) u1[i] <= u1[i-1];
  end
  assign sr_v0 = (u0[DW] & ~drop0) | stray0;
  assign sr_d0 = u0[DW-1:0];
  assign sr_v1 = u1[7][DW];
  assign sr_d1 = u1[7][DW-1:0];

  typedef struct {
    logic [NR-1:0] oh;
    logic [DW-1:0] d;
    int            t;
  } exp_t;

  exp_t q0[$], q1[$];
  int   gseq0[$];
  int   rcnt1 = 0;
  logic sb_en0 = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (!rstn0) q0.delete();
    else begin
      chk("ready_wo_valid0", 32'(rr0 & ~rv0), 0);
      chk("ready_onehot0", 32'($countones(rr0) <= 1), 1);
      chk("b_tvalid0", 32'(mb_v0), 32'(ma_v0));
      for (int i = 0; i < NR; i++)
        if (rv0[i] && rr0[i]) begin
          gseq0.push_back(i);
          if (sb_en0) q0.push_back('{oh: NR'(1) << i, d: model(ra0, rb0, i), t: cyc});
        end
      if (sb_en0 && sv0 != '0) begin
        if (q0.size() == 0) chk("rsp_unexpected0", 32'(sv0), 0);
        else begin
          e = q0.pop_front();
          chk("rsp_id0", 32'(sv0), 32'(e.oh));
          chk("rsp_data0", sd0, e.d);
          chk("rsp_latency0", cyc - e.t, 3);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rstn1) q1.delete();
    else begin
      chk("ready_wo_valid1", 32'(rr1 & ~rv1), 0);
      for (int i = 0; i < NR; i++)
        if (rv1[i] && rr1[i]) q1.push_back('{oh: NR'(1) << i, d: model(ra1, rb1, i), t: cyc});
      if (sv1 != '0) begin
        rcnt1++;
        if (q1.size() == 0) chk("rsp_unexpected1", 32'(sv1), 0);
        else begin
          e = q1.pop_front();
          chk("rsp_id1", 32'(sv1), 32'(e.oh));
          chk("rsp_data1", sd1, e.d);
          chk("rsp_latency1", cyc - e.t, 10);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd0(input logic [NR-1:0] hs);
    for (int i = 0; i < NR; i++) if (hs[i]) ra0[i*DW +: DW] = $urandom;
  endtask

  typedef struct {
    int            req;
    logic [DW-1:0] a;
    logic          b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl [5];
  int            n, gstart, cnt, peak;
  logic [NR-1:0] hs;

  initial begin
    tbl[0] = '{0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    tbl[1] = '{2, 32'h0000_0005, 1'b1, 32'h0000_0005};
    tbl[2] = '{1, 32'h0000_1234, 1'b0, 32'h0000_0001};
    tbl[3] = '{0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[4] = '{3, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};

    rstn0 = 1'b0; rstn1 = 1'b0;
    rv0 = '1; rv1 = '1; rb0 = '1; rb1 = 4'b1011;
    for (int i = 0; i < NR; i++) begin
      ra0[i*DW +: DW] = $urandom;
      ra1[i*DW +: DW] = $urandom;
    end
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready0", 32'(rr0), 0);   chk("rst_rsp_valid0", 32'(sv0), 0);
    chk("rst_rsp_data0", sd0, 0);     chk("rst_tvalid0", 32'(ma_v0), 0);
    chk("rst_tdata0", ma_d0, 0);      chk("rst_bdata0", 32'(mb_d0), 0);
    chk("rst_inflight0", 32'(inf0), 0); chk("rst_err0", 32'(err0), 0);
    chk("rst_ready1", 32'(rr1), 0);   chk("rst_tvalid1", 32'(ma_v1), 0);
    chk("rst_inflight1", 32'(inf1), 0); chk("rst_err1", 32'(err1), 0);

    // Guard after first release: ready held low for MUL_LATENCY+1 cycles.
    tick(); rstn0 = 1'b1; rv0 = 4'b0001;
    n = 0; @(negedge clk);
    while (rr0 == '0 && n < 20) begin n++; @(negedge clk); end
    chk("guard0", n, 2);
    tick(); rv0 = '0;
    repeat (4) tick();

    for (int k = 0; k < 5; k++) begin
      ra0[tbl[k].req*DW +: DW] = tbl[k].a;
      rb0[tbl[k].req] = tbl[k].b;
      rv0 = '0; rv0[tbl[k].req] = 1'b1;
      n = 0; @(negedge clk);
      while (!rr0[tbl[k].req] && n < 10) begin n++; @(negedge clk); end
      chk("tbl_grant_wait", n, 0);
      tick(); rv0 = '0;
      @(negedge clk); chk("tbl_inflight_t1", 32'(inf0), 1); chk("tbl_quiet_t1", 32'(sv0), 0);
      tick(); @(negedge clk); chk("tbl_quiet_t2", 32'(sv0), 0);
      tick(); @(negedge clk);
      chk("tbl_rsp_valid", 32'(sv0), 32'(1) << tbl[k].req);
      chk("tbl_rsp_data", sd0, tbl[k].exp);
      chk("tbl_inflight_t3", 32'(inf0), 0);
      tick();
    end

    // All four requesters valid for 8 cycles; requester 1 uses b=0.
    rb0 = 4'b1101; gstart = gseq0.size(); rv0 = '1;
    repeat (8) begin
      @(negedge clk); hs = rv0 & rr0;
      tick(); upd0(hs);
    end
    rv0 = '0;
    repeat (6) tick();
    chk("rr_count", gseq0.size() - gstart, 8);
    for (int k = 0; k < 8; k++) chk("rr_order", gseq0[gstart+k], k % 4);
    chk("stream_drained", q0.size(), 0);

    // Fairness: requester 0 always valid, requester 3 toggles.
    rb0 = '1; gstart = gseq0.size(); rv0 = 4'b0001;
    for (int r = 0; r < 4; r++) begin
      rv0[3] = 1'b1;
      n = 0; @(negedge clk);
      while (!rr0[3] && n < 8) begin n++; @(negedge clk); end
      chk("fair_wait3", 32'(n < NR), 1);
      tick(); rv0[3] = 1'b0;
      repeat (2) tick();
    end
    rv0 = '0;
    cnt = 0;
    for (int k = gstart; k < gseq0.size(); k++) if (gseq0[k] == 0) cnt++;
    chk("no_starve0", 32'(cnt > 0), 1);
    repeat (5) tick();
    chk("fair_drained", q0.size(), 0);

    // Dropped result: err rises next cycle, response missing.
    sb_en0 = 1'b0;
    ra0[2*DW +: DW] = 32'd7; rb0[2] = 1'b1; rv0 = 4'b0100;
    n = 0; @(negedge clk);
    while (!rr0[2] && n < 10) begin n++; @(negedge clk); end
    chk("mm_grant_wait", 32'(n < 10), 1);
    tick(); rv0 = '0;
    tick(); drop0 = 1'b1;
    @(negedge clk); chk("mm_err_not_yet", 32'(err0), 0); chk("mm_quiet", 32'(sv0), 0);
    tick(); drop0 = 1'b0;
    @(negedge clk);
    chk("mm_err_rise", 32'(err0), 1);
    chk("mm_rsp_missing", 32'(sv0), 0);
    chk("mm_inflight", 32'(inf0), 0);
    repeat (3) begin tick(); @(negedge clk); chk("mm_err_sticky", 32'(err0), 1); end

    // Reset with two operations in flight; the stale unit result lands during the guard.
    sb_en0 = 1'b1; rv0 = 4'b0011;
    repeat (3) begin
      @(negedge clk); hs = rv0 & rr0;
      tick(); upd0(hs);
    end
    @(negedge clk); chk("rst_mid_inflight", 32'(inf0), 2);
    tick(); rstn0 = 1'b0; rv0 = '0;
    tick(); rstn0 = 1'b1; rv0 = 4'b0001;
    n = 0; @(negedge clk);
    while (rr0 == '0 && n < 20) begin
      chk("rst_mid_no_rsp", 32'(sv0), 0);
      chk("rst_mid_err_clear", 32'(err0), 0);
      n++; @(negedge clk);
    end
    chk("rst_mid_guard", n, 2);
    tick(); rv0 = '0;
    repeat (5) tick();
    chk("rst_mid_drained", q0.size(), 0);
    @(negedge clk); chk("rst_mid_err_after", 32'(err0), 0);

    // Stray result with nothing in flight.
    tick(); stray0 = 1'b1;
    tick(); stray0 = 1'b0;
    @(negedge clk);
    chk("stray_err", 32'(err0), 1);
    chk("stray_no_rsp", 32'(sv0), 0);

    // Latency-8 instance: 20 back-to-back operations.
    tick(); rstn1 = 1'b1;
    n = 0; @(negedge clk);
    while (rr1 == '0 && n < 30) begin n++; @(negedge clk); end
    chk("guard1", n, 9);
    cnt = 0; peak = 0;
    for (int k = 0; k < 100 && cnt < 20; k++) begin
      if (int'(inf1) > peak) peak = int'(inf1);
      hs = rv1 & rr1;
      if (hs != '0) cnt++;
      tick();
      for (int i = 0; i < NR; i++) if (hs[i]) ra1[i*DW +: DW] = $urandom;
      if (cnt >= 20) rv1 = '0;
      @(negedge clk);
    end
    repeat (14) begin
      if (int'(inf1) > peak) peak = int'(inf1);
      @(negedge clk);
    end
    chk("l8_issued", cnt, 20);
    chk("l8_inflight_peak", peak, 9);
    chk("l8_responses", rcnt1, 20);
    chk("l8_drained", q1.size(), 0);
    chk("l8_inflight_end", 32'(inf1), 0);
    chk("l8_err", 32'(err1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_share_sched.md
Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency multiply unit among NREQ requesters.
- The multiply unit is AXI-stream style: a/b valid+data in, result valid+data out, no backpressure, result MUL_LATENCY cycles after input.
- The block grants one requester per cycle and drives the unit's operands.
- It tags each issue, routes each returned result to the requester that issued it, and flags tag/result mismatches.

Parameters:
- DATAWIDTH, 32, width of operand a and of the result.
- BWIDTH, 1, width of operand b.
- NREQ, 4, number of requesters (2..16).
- MUL_LATENCY, 1, cycles from multiply-unit input valid to result valid (1..16).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a_data  in  NREQ*DATAWIDTH  flattened operand a; requester i at bits [i*DATAWIDTH +: DATAWIDTH].
- req_b_data  in  NREQ*BWIDTH  flattened operand b.
- rsp_valid  out  NREQ  per-requester result strobe, one-hot or zero.
- rsp_data  out  DATAWIDTH  result data, shared by all requesters, qualified by rsp_valid.
- m_axis_a_tvalid  out  1  operand a valid to multiply unit.
- m_axis_a_tdata  out  DATAWIDTH  operand a to multiply unit.
- m_axis_b_tvalid  out  1  operand b valid; always equal to m_axis_a_tvalid.
- m_axis_b_tdata  out  BWIDTH  operand b to multiply unit.
- s_axis_result_tvalid  in  1  result valid from multiply unit.
- s_axis_result_tdata  in  DATAWIDTH  result from multiply unit.
- inflight  out  clog2(MUL_LATENCY+2)  operations issued and not yet returned.
- err  out  1  sticky tag/result mismatch flag.

Behaviour:
- Reset (aresetn=0 at posedge):
  - All outputs go to 0, including m_axis_*_tdata and rsp_data.
  - Round-robin pointer goes to 0 and the tag pipeline is cleared.
  - The guard counter is loaded with MUL_LATENCY+1.
- Arbitration:
  - Combinational and round-robin, starting at the pointer.
  - req_ready[i]=1 only for the granted i, and only if req_valid[i]=1 and the guard counter is 0.
  - Handshake occurs when req_valid[i] & req_ready[i].
  - req_ready never asserts without a matching valid.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Issue:
  - In handshake cycle t, the operands are registered.
  - At t+1: m_axis_a/b_tvalid=1 with the captured data.
  - With no handshake, tvalid=0 and tdata=0.
- Tag pipeline:
  - Shift register of depth MUL_LATENCY carrying {valid, clog2(NREQ)-bit id}.
  - Loaded from the issue register; it advances every cycle.
  - The head aligns with s_axis_result_tvalid at t+1+MUL_LATENCY.
- Response:
  - At t+2+MUL_LATENCY: rsp_valid[id]=1 and rsp_data=result, one cycle only.
  - Requester-visible latency is MUL_LATENCY+2 (3 for the default).
  - Throughput is one operation per cycle; back-to-back issues give back-to-back responses in issue order.
- Mismatch handling:
  - Head valid with s_axis_result_tvalid=0: set err, drop the tag, no rsp_valid.
  - s_axis_result_tvalid=1 with head invalid: set err, drop the result.
  - err clears only on reset.
- inflight:
  - +1 on handshake, -1 on head-valid pop.
  - On a simultaneous push and pop, the value holds.
- Guard counter:
  - Decrements to 0 after reset release.
  - While it is nonzero, there are no grants, and stray results are dropped silently without setting err. This flushes stale pipeline contents from a multiply unit that has no reset.
- Reset mid-operation: in-flight operations are lost and no rsp_valid is produced for them. Requesters must reissue.

Decomposition:
- mul_sched_pkg holds:
  - the ID_W localparam function, clog2(NREQ) min 1;
  - the tag struct typedef {logic vld; logic [ID_W-1:0] id};
  - the guard-count width constant.
- Sub-module rr_arbiter (NREQ): req, pointer, enable -> one-hot grant, next pointer. It is reused by other shared-unit schedulers.

Test Plan:
- Single request, NREQ=4, MUL_LATENCY=1: req 2 with a=0x0000_0005, b=1; the unit returns a when b=1, else 1. Expect rsp_valid=4'b0100 and rsp_data=5 exactly 3 cycles after the handshake, with inflight returning to 0.
- All four requesters valid continuously for 8 cycles:
  - grants in order 0,1,2,3,0,1,2,3, one per cycle;
  - responses in the same order with matching data;
  - b=0 on requester 1 yields rsp_data=1.
- Fairness: req 0 held valid while req 3 toggles. req 3 is granted within at most NREQ cycles of asserting, and no requester is starved.
- Injected mismatch: force s_axis_result_tvalid=0 on one expected cycle. err rises next cycle and stays 1, and that response is missing. A forced stray valid also sets err.
- Reset mid-stream: assert aresetn=0 with 2 operations in flight, and have the unit emit 1 stale result after release. Expect:
  - no rsp_valid and err=0;
  - req_ready=0 for MUL_LATENCY+1 cycles, then normal grants resume.
- MUL_LATENCY=8 back-to-back: issue 20 operations. inflight peaks at 9 (8 in the tag pipe plus 1 in the issue register), and all 20 responses return in order.
